// File: rtl/tpu_pkg.sv
// Shared types and default widths for the compute-core writeback path.
package tpu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned CLIP_MAX_DEF   = 6;
  localparam int unsigned NUM_ENTRIES    = 2;

  typedef enum logic [1:0] {
    ACT_PASS = 2'b00,
    ACT_RELU = 2'b01,
    ACT_CLIP = 2'b10
  } act_mode_e;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_WRITE = 2'b01,
    WB_DONE  = 2'b10
  } wb_state_e;

endpackage

// File: rtl/acc_writeback_if.sv
// Valid/ready write port into the unified buffer.
interface acc_writeback_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/acc_writeback_act_unit.sv
// Activation function applied to one signed accumulator word.
module act_unit
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CLIP_MAX   = CLIP_MAX_DEF
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  act_mode_e             mode,
  output logic [DATA_WIDTH-1:0] y_c
);

  logic [DATA_WIDTH-1:0] relu;

  // Negative inputs (sign bit set) clamp to zero; clip compares unsigned once non-negative.
  always_comb begin
    relu = x[DATA_WIDTH-1] ? '0 : x;
    y_c  = x;
    case (mode)
      ACT_RELU: y_c = relu;
      ACT_CLIP: y_c = (relu > DATA_WIDTH'(CLIP_MAX)) ? DATA_WIDTH'(CLIP_MAX) : relu;
      default:  y_c = x;
    endcase
  end

endmodule

// File: rtl/acc_writeback.sv
// Captures a full accumulator, activates each word and writes it to the unified buffer.
module acc_writeback
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CLIP_MAX   = CLIP_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  acc_full,
  input  logic [DATA_WIDTH-1:0] acc_mem_0,
  input  logic [DATA_WIDTH-1:0] acc_mem_1,
  input  logic [1:0]            act_mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  acc_writeback_if.master       wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  wb_state_e             state;
  logic                  full_q;
  logic                  start;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] mem_in   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] act_out  [NUM_ENTRIES];
  act_mode_e             mode;

  logic                  wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  assign mem_in[0] = acc_mem_0;
  assign mem_in[1] = acc_mem_1;
  assign mode      = act_mode_e'(act_mode);
  assign start     = acc_full & ~full_q;
  assign idx_nxt   = idx_q + IDX_W'(1);

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;

  for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_act
    act_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .CLIP_MAX   (CLIP_MAX)
    ) u_act (
      .x    (mem_in[k]),
      .mode (mode),
      .y_c  (act_out[k])
    );
  end

  // Writeback FSM with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WB_IDLE;
      full_q     <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      for (int k = 0; k < NUM_ENTRIES; k++) data_q[k] <= '0;
    end else begin
      full_q <= acc_full;
      if (start && state != WB_IDLE) overrun <= 1'b1;
      case (state)
        WB_IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int k = 0; k < NUM_ENTRIES; k++) data_q[k] <= act_out[k];
            addr_q     <= base_addr;
            idx_q      <= '0;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= base_addr;
            wr_data_q  <= act_out[0];
            busy       <= 1'b1;
            state      <= WB_WRITE;
          end
        end
        WB_WRITE: begin
          if (wr.wr_ready) begin
            if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
              wr_valid_q <= 1'b0;
              wr_addr_q  <= '0;
              wr_data_q  <= '0;
              done       <= 1'b1;
              state      <= WB_DONE;
            end else begin
              idx_q     <= idx_nxt;
              wr_addr_q <= addr_q + ADDR_WIDTH'(idx_nxt);
              wr_data_q <= data_q[idx_nxt];
            end
          end
        end
        WB_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx_q <= '0;
          state <= WB_IDLE;
        end
        default: begin
          wr_valid_q <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= WB_IDLE;
        end
      endcase
    end
  end

endmodule
